// File: rtl/udp2fifoc.sv
// Command-path receive front end: stages one UDP command frame, validates length and
// header, replays it into fifoc and hands it to the parser over the fs/fd handshake.
module udp2fifoc #(
    parameter int FRAME_LEN = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       udp_rxv,
    input  logic [7:0] udp_rxd,
    input  logic       udp_rxl,
    output logic       fifoc_txen,
    output logic [7:0] fifoc_txd,
    input  logic       fifoc_full,
    output logic       fs,
    input  logic       fd,
    input  logic       cs_err,
    output logic       err,
    output logic [7:0] drop_cnt
);

    typedef enum logic [3:0] {
        IDLE, RECV, CHEK, DROP, LOAD, GAP, SEND, HOLD, ERR
    } state_t;

    localparam logic [4:0] FL     = 5'(FRAME_LEN);
    localparam logic [4:0] FL_OVF = 5'(FRAME_LEN + 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic        skip_q, skip_d;
    logic [7:0]  drop_q, drop_d;
    logic        txen_q, txen_d;
    logic [7:0]  txd_q, txd_d;
    logic [7:0]  mem_q [16];
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [1:0]  drop_inc;
    logic        busy;

    function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Any state between frame capture and handshake completion rejects new datagrams.
    assign busy = (state_q == CHEK) || (state_q == DROP) || (state_q == LOAD) ||
                  (state_q == GAP)  || (state_q == SEND) || (state_q == HOLD);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        skip_d   = skip_q;
        txen_d   = 1'b0;
        txd_d    = txd_q;
        wr_en    = 1'b0;
        wr_idx   = cnt_q[3:0];
        drop_inc = 2'd0;

        if (busy && udp_rxv) begin
            if (udp_rxl) begin
                drop_inc = 2'd1;
                skip_d   = 1'b0;
            end else begin
                skip_d   = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (skip_q) begin
                    if (udp_rxv && udp_rxl) skip_d = 1'b0;
                end else if (udp_rxv) begin
                    wr_en   = 1'b1;
                    wr_idx  = 4'd0;
                    cnt_d   = 5'd1;
                    state_d = udp_rxl ? CHEK : RECV;
                end
            end
            RECV: begin
                if (udp_rxv) begin
                    wr_en = (cnt_q < FL);
                    if (cnt_q != FL_OVF) cnt_d = cnt_q + 5'd1;
                    if (udp_rxl) state_d = CHEK;
                end
            end
            CHEK: begin
                if (cnt_q == FL && mem_q[0] == 8'h55 && mem_q[1] == 8'hAA) begin
                    state_d = LOAD;
                    rd_d    = 5'd0;
                end else begin
                    state_d = DROP;
                end
            end
            DROP: begin
                drop_inc = drop_inc + 2'd1;
                state_d  = IDLE;
            end
            // The write for the last byte is still on the output when LOAD exits.
            LOAD: begin
                if (rd_q == FL) begin
                    state_d = GAP;
                end else if (!fifoc_full) begin
                    txen_d = 1'b1;
                    txd_d  = mem_q[rd_q[3:0]];
                    rd_d   = rd_q + 5'd1;
                end
            end
            GAP:  state_d = SEND;
            SEND: begin
                if (cs_err)  state_d = ERR;
                else if (fd) state_d = HOLD;
            end
            HOLD: begin
                if (!fd) state_d = IDLE;
            end
            ERR:  state_d = ERR;
            default: state_d = IDLE;
        endcase

        drop_d = (state_q == ERR) ? drop_q : sat_add(drop_q, drop_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            rd_q    <= 5'd0;
            skip_q  <= 1'b0;
            drop_q  <= 8'd0;
            txen_q  <= 1'b0;
            txd_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            skip_q  <= skip_d;
            drop_q  <= drop_d;
            txen_q  <= txen_d;
            txd_q   <= txd_d;
        end
    end

    // Frame storage is pure data; its contents are only trusted after CHEK.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= udp_rxd;
    end

    assign fifoc_txen = txen_q;
    assign fifoc_txd  = txd_q;
    assign fs         = (state_q == SEND);
    assign err        = (state_q == ERR);
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_udp2fifoc.sv
// Bench for udp2fifoc: directed frames with literal expectations plus randomized datagrams
// checked every cycle against a queue-based frame model.
module tb_udp2fifoc;

    localparam int FL = 12;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       udp_rxv = 1'b0;
    logic [7:0] udp_rxd = 8'd0;
    logic       udp_rxl = 1'b0;
    logic       fifoc_full = 1'b0;
    logic       fd = 1'b0;
    logic       cs_err = 1'b0;
    logic       fifoc_txen, fs, err;
    logic [7:0] fifoc_txd, drop_cnt;

    udp2fifoc #(.FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n),
        .udp_rxv(udp_rxv), .udp_rxd(udp_rxd), .udp_rxl(udp_rxl),
        .fifoc_txen(fifoc_txen), .fifoc_txd(fifoc_txd), .fifoc_full(fifoc_full),
        .fs(fs), .fd(fd), .cs_err(cs_err), .err(err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", nm, cyc, act, exp);
        end
    endtask

    // Frame-level model: 0 listen, 1 collect, 2 judge, 3 reject, 4 replay, 5 gap,
    // 6 offer to parser, 7 wait release, 8 dead
    int         ph;
    bit         mskip;
    logic [7:0] pkt[$];
    logic [7:0] pend[$];
    int         mdrop;
    bit         e_txen;
    logic [7:0] e_txd;

    task automatic mreset();
        ph = 0; mskip = 0; mdrop = 0; e_txen = 0; e_txd = 8'd0;
        pkt.delete(); pend.delete();
    endtask

    task automatic mstep();
        int inc;
        bit ntx;
        inc = 0; ntx = 0;
        if (ph >= 2 && ph <= 7 && udp_rxv) begin
            if (udp_rxl) begin inc++; mskip = 0; end
            else mskip = 1;
        end
        case (ph)
            0: if (mskip) begin
                   if (udp_rxv && udp_rxl) mskip = 0;
               end else if (udp_rxv) begin
                   pkt.delete(); pkt.push_back(udp_rxd);
                   ph = udp_rxl ? 2 : 1;
               end
            1: if (udp_rxv) begin
                   pkt.push_back(udp_rxd);
                   if (udp_rxl) ph = 2;
               end
            2: if (pkt.size() == FL && pkt[0] == 8'h55 && pkt[1] == 8'hAA) begin
                   pend = pkt; ph = 4;
               end else ph = 3;
            3: begin inc++; ph = 0; end
            4: if (pend.size() == 0) ph = 5;
               else if (!fifoc_full) begin ntx = 1; e_txd = pend.pop_front(); end
            5: ph = 6;
            6: if (cs_err) ph = 8; else if (fd) ph = 7;
            7: if (!fd) ph = 0;
            default: ;
        endcase
        e_txen = ntx;
        mdrop = (mdrop + inc > 255) ? 255 : mdrop + inc;
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) mreset();
            else mstep();
        end
    end

    logic [7:0] wr_log[$];
    int         wr_cyc[$];
    int         fs_rise = -1000;
    int         fs_fall = -1000;
    bit         fs_prev = 0;

    task automatic clear_log();
        wr_log.delete(); wr_cyc.delete();
        fs_rise = -1000; fs_fall = -1000;
    endtask

    initial forever begin
        @(negedge clk);
        chk("txen", 32'(fifoc_txen), 32'(e_txen));
        chk("txd", 32'(fifoc_txd), 32'(e_txd));
        chk("fs", 32'(fs), 32'(ph == 6));
        chk("err", 32'(err), 32'(ph == 8));
        chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
        if (fifoc_txen === 1'b1) begin wr_log.push_back(fifoc_txd); wr_cyc.push_back(cyc); end
        if (fs === 1'b1 && !fs_prev) fs_rise = cyc;
        if (fs !== 1'b1 && fs_prev) fs_fall = cyc;
        fs_prev = (fs === 1'b1);
    end

    // Parser stand-in: answers fs after fd_delay cycles, releases one cycle after fs falls.
    int fd_delay = 0;
    bit err_mode = 0;
    initial begin
        int pc;
        bit rel;
        pc = 0; rel = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                fd = 0; cs_err = 0; pc = 0; rel = 0;
            end else if (fs && !fd && !cs_err) begin
                if (pc >= fd_delay) begin
                    if (err_mode) cs_err = 1; else fd = 1;
                    pc = 0;
                end else pc++;
            end else if (!fs && (fd || cs_err)) begin
                if (rel) begin fd = 0; cs_err = 0; rel = 0; end
                else rel = 1;
            end
        end
    end

    bit full_rand = 0;
    bit full_force = 0;
    initial forever begin
        @(posedge clk); #1;
        fifoc_full = full_rand ? ($urandom_range(0, 3) == 0) : full_force;
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            udp_rxv = 0; udp_rxl = 1'($urandom_range(0, 1)); udp_rxd = 8'($urandom);
        end
    endtask

    task automatic send(input bq_t d, input int gap_pct, output int t_last);
        t_last = cyc;
        for (int i = 0; i < d.size(); i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                tick(); udp_rxv = 0; udp_rxl = 0;
            end
            tick();
            udp_rxv = 1; udp_rxd = d[i]; udp_rxl = (i == d.size() - 1);
            t_last = cyc;
        end
        tick(); udp_rxv = 0; udp_rxl = 0;
    endtask

    task automatic rst_pulse();
        tick(); rst_n = 0;
        tick(); tick(); rst_n = 1;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        while (ph != 0 && n < budget) begin tick(); n++; end
        chk(nm, 32'(n < budget), 32'd1);
    endtask

    function automatic bq_t sample();
        bq_t q;
        q = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h2D};
        return q;
    endfunction

    function automatic bq_t rand_good();
        bq_t q;
        logic [7:0] s;
        s = 8'd0;
        q.push_back(8'h55); q.push_back(8'hAA);
        for (int i = 0; i < FL - 3; i++) begin
            q.push_back(8'($urandom)); s = s + q[q.size() - 1];
        end
        q.push_back(s);
        return q;
    endfunction

    task automatic chk_bytes(input string nm, input bq_t f);
        chk({nm, "_nwr"}, 32'(wr_log.size()), 32'(f.size()));
        if (wr_log.size() == f.size())
            for (int i = 0; i < f.size(); i++) chk({nm, "_byte"}, 32'(wr_log[i]), 32'(f[i]));
    endtask

    initial begin
        bq_t f;
        int tl;
        int n;

        idle(3);
        chk("rst_txen", 32'(fifoc_txen), 32'd0);
        chk("rst_txd", 32'(fifoc_txd), 32'd0);
        chk("rst_fs", 32'(fs), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        rst_n = 1;
        idle(2);

        // good frame with literal timing
        clear_log(); f = sample();
        send(f, 0, tl);
        wait_idle("good_idle", 100);
        chk_bytes("good", f);
        chk("good_first_wr", 32'((wr_cyc.size() > 0 ? wr_cyc[0] : -1000) - tl), 32'd3);
        chk("good_last_wr", 32'((wr_cyc.size() > 11 ? wr_cyc[11] : -1000) - tl), 32'd14);
        chk("good_fs_rise", 32'(fs_rise - tl), 32'd16);
        chk("good_fs_fall", 32'(fs_fall - fs_rise), 32'd1);
        chk("good_drop", 32'(drop_cnt), 32'd0);

        // short and long frames
        clear_log(); f = sample(); void'(f.pop_back());
        send(f, 0, tl); wait_idle("short_idle", 50);
        chk("short_nwr", 32'(wr_log.size()), 32'd0);
        chk("short_fs", 32'(fs_rise), 32'(-1000));
        chk("short_drop", 32'(drop_cnt), 32'd1);
        f = sample(); f.push_back(8'h77);
        send(f, 0, tl); wait_idle("long_idle", 50);
        chk("long_nwr", 32'(wr_log.size()), 32'd0);
        chk("long_drop", 32'(drop_cnt), 32'd2);

        // bad header
        rst_pulse(); clear_log(); f = sample(); f[1] = 8'hAB;
        send(f, 0, tl); wait_idle("hdr_idle", 50);
        chk("hdr_nwr", 32'(wr_log.size()), 32'd0);
        chk("hdr_drop", 32'(drop_cnt), 32'd1);

        // datagram arriving while the frame sits in SEND
        rst_pulse(); clear_log(); fd_delay = 20; f = sample();
        send(f, 0, tl);
        n = 0;
        while (fs !== 1'b1 && n < 60) begin tick(); n++; end
        chk("busy_fs", 32'(fs), 32'd1);
        send(sample(), 0, tl);
        wait_idle("busy_idle", 100);
        chk("busy_nwr", 32'(wr_log.size()), 32'd12);
        chk("busy_drop", 32'(drop_cnt), 32'd1);
        fd_delay = 0; clear_log(); f = rand_good();
        send(f, 0, tl); wait_idle("third_idle", 100);
        chk_bytes("third", f);
        chk("third_drop", 32'(drop_cnt), 32'd1);

        // fifoc_full stall after 4th write, then parser error
        rst_pulse(); clear_log(); err_mode = 1; f = sample();
        send(f, 0, tl);
        while (cyc < tl + 5) tick();
        full_force = 1;
        while (cyc < tl + 8) tick();
        full_force = 0;
        n = 0;
        while (err !== 1'b1 && n < 80) begin tick(); n++; end
        chk("stall_err", 32'(err), 32'd1);
        chk_bytes("stall", f);
        chk("stall_5th_wr", 32'((wr_cyc.size() > 4 ? wr_cyc[4] : -1000) - tl), 32'd10);
        chk("stall_fs_rise", 32'(fs_rise - tl), 32'd19);
        err_mode = 0; clear_log();
        send(sample(), 0, tl); idle(30);
        chk("dead_nwr", 32'(wr_log.size()), 32'd0);
        chk("dead_err", 32'(err), 32'd1);
        chk("dead_drop", 32'(drop_cnt), 32'd0);
        rst_pulse();
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);

        // reset in the middle of replay
        clear_log(); send(sample(), 0, tl);
        while (cyc < tl + 9) tick();
        chk("mid_nwr", 32'(wr_log.size()), 32'd6);
        #1 rst_n = 0; #1;
        chk("mid_txen", 32'(fifoc_txen), 32'd0);
        chk("mid_txd", 32'(fifoc_txd), 32'd0);
        chk("mid_fs", 32'(fs), 32'd0);
        tick(); tick(); rst_n = 1;
        clear_log(); f = sample();
        send(f, 0, tl); wait_idle("mid_idle", 100);
        chk_bytes("after_rst", f);

        // drop counter saturation
        f = '{8'h55, 8'hAA, 8'h01};
        for (int k = 0; k < 260; k++) begin send(f, 0, tl); idle(2); end
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        rst_pulse();

        // randomized traffic
        full_rand = 1;
        for (int k = 0; k < 300; k++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 9);
            f = rand_good();
            if (kind == 6) f[1] = 8'hA0 + 8'($urandom_range(0, 9));
            else if (kind == 7) f[0] = 8'h54;
            else if (kind == 8) begin
                len = $urandom_range(1, FL - 1);
                while (f.size() > len) void'(f.pop_back());
            end else if (kind == 9) begin
                len = $urandom_range(FL + 1, 16);
                while (f.size() < len) f.push_back(8'($urandom));
            end
            fd_delay = $urandom_range(0, 4);
            err_mode = ($urandom_range(0, 39) == 0);
            send(f, ($urandom_range(0, 1) == 1) ? 15 : 0, tl);
            idle($urandom_range(0, 18));
            if (ph == 8 || $urandom_range(0, 29) == 0) rst_pulse();
        end
        full_rand = 0; err_mode = 0;
        idle(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog at cycle %0d: actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
